// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one full-subtractor
// cell and a single borrow flop. Start/done handshake; result held in diff/bout.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_br_nxt;

    // New operands are only taken when no operation is in flight.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);

    // Full-subtractor cell on the current LSBs.
    assign w_d      = r_ra[0] ^ r_rb[0] ^ r_br;
    assign w_br_nxt = (~r_ra[0] & r_rb[0]) | (~(r_ra[0] ^ r_rb[0]) & r_br);

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: accept in IDLE/DONE, leave SHIFT after the last bit.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_SHIFT : S_IDLE;
            S_SHIFT: w_next = w_last ? S_DONE : S_SHIFT;
            S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand/result shifting; diff and bout only change on the final bit step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra  <= '0;
            r_rb  <= '0;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
            diff  <= '0;
            bout  <= 1'b0;
        end else if (w_accept) begin
            r_ra  <= a;
            r_rb  <= b;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            r_ra  <= r_ra >> 1;
            r_rb  <= r_rb >> 1;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_br  <= w_br_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                diff <= {w_d, r_res[WIDTH-1:1]};
                bout <= w_br_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       bout;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at the negedge right after the accepting edge; returns edges to done.
    task automatic wait_done(output int cyc, output int bc, output bit got, output int ov);
        cyc = 1;
        bc  = 0;
        got = 1'b0;
        ov  = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy && done) ov++;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_op(input string nm, input logic [3:0] ia, input logic [3:0] ib,
                         input logic [3:0] ed, input logic ebo, input bit timing);
        int cyc, bc, ov;
        bit got;
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc, got, ov);
        chk({nm, " done_seen"}, 32'(got), 32'd1);
        if (timing) begin
            chk({nm, " latency"}, 32'(cyc), 32'd5);
            chk({nm, " busy_cycles"}, 32'(bc), 32'd4);
            chk({nm, " overlap"}, 32'(ov), 32'd0);
        end
        chk({nm, " diff"}, 32'(diff), 32'(ed));
        chk({nm, " bout"}, 32'(bout), 32'(ebo));
        @(negedge clk);
        if (timing) chk({nm, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc, bc, ov, ndone;
        bit got;
        logic [3:0] first_d;
        logic       first_bo;

        vecs[0] = '{"v_1010_1001", 4'b1010, 4'b1001, 4'b0001, 1'b0};
        vecs[1] = '{"v_0010_0011", 4'b0010, 4'b0011, 4'b1111, 1'b1};
        vecs[2] = '{"v_0000_0001", 4'b0000, 4'b0001, 4'b1111, 1'b1};
        vecs[3] = '{"v_0101_0101", 4'b0101, 4'b0101, 4'b0000, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst diff", 32'(diff), 32'd0);
        chk("rst bout", 32'(bout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < 4; i++)
            do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, 1'b1);

        // Start during busy is ignored.
        @(negedge clk);
        a = 4'b0100; b = 4'b0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 4'b1111; b = 4'b0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        first_d = 4'hx;
        first_bo = 1'bx;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                if (ndone == 0) begin
                    first_d  = diff;
                    first_bo = bout;
                end
                ndone++;
            end
            @(negedge clk);
        end
        chk("busy_start diff", 32'(first_d), 32'h3);
        chk("busy_start bout", 32'(first_bo), 32'd0);
        chk("busy_start done_count", 32'(ndone), 32'd1);

        // Back-to-back with start held high.
        a = 4'b1001; b = 4'b1010; start = 1'b1;
        @(negedge clk);
        wait_done(cyc, bc, got, ov);
        chk("b2b1 done_seen", 32'(got), 32'd1);
        chk("b2b1 latency", 32'(cyc), 32'd5);
        chk("b2b1 busy_cycles", 32'(bc), 32'd4);
        chk("b2b1 busy_in_done", 32'(busy), 32'd0);
        chk("b2b1 diff", 32'(diff), 32'hF);
        chk("b2b1 bout", 32'(bout), 32'd1);
        a = 4'b1111; b = 4'b0001;
        @(negedge clk);
        start = 1'b0;
        chk("b2b2 busy_after_accept", 32'(busy), 32'd1);
        chk("b2b2 diff_held", 32'(diff), 32'hF);
        wait_done(cyc, bc, got, ov);
        chk("b2b2 done_seen", 32'(got), 32'd1);
        chk("b2b2 spacing", 32'(cyc), 32'd5);
        chk("b2b2 busy_cycles", 32'(bc), 32'd4);
        chk("b2b2 overlap", 32'(ov), 32'd0);
        chk("b2b2 diff", 32'(diff), 32'hE);
        chk("b2b2 bout", 32'(bout), 32'd0);
        @(negedge clk);

        // Leave a nonzero result so the reset visibly clears it.
        do_op("pre_rst", 4'b0010, 4'b0011, 4'b1111, 1'b1, 1'b0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        a = 4'b1000; b = 4'b0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("midrst busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst diff", 32'(diff), 32'd0);
        chk("midrst bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        bc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) bc++;
        end
        chk("postrst done_count", 32'(ndone), 32'd0);
        chk("postrst busy_count", 32'(bc), 32'd0);

        // Exhaustive sweep.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                do_op($sformatf("sweep a=%0d b=%0d", ia, ib), 4'(ia), 4'(ib),
                      4'((ia - ib) & 15), (ia < ib), 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
